// File: rtl/cpu_serial_tx.sv
// cpu_serial_tx -- serialises an ALU result word and its flags onto a
// one-bit stream with a start marker and a completion pulse.
//
// Frame: START marker beat, 8 result bits (MSB first), 4 flag bits
// (N,V,Z,C), optional even-parity beat, then a one-cycle DONE.
//
// Optional feature: define CPU_SERIAL_TX_PARITY_EN to append a parity beat
// carrying the XOR of all 12 captured bits.
//
// Handshake: a beat (START, data or parity) is presented on the outputs and
// held unchanged until a rising edge with tx_ready=1 accepts it; the next
// beat appears right after that edge. DONE does not wait for tx_ready.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   load        in   capture y_in/flags_in and start a frame (IDLE only)
//   y_in[7:0]   in   result word
//   flags_in    in   {N,V,Z,C}
//   tx_ready    in   far end accepts the current beat
//   tx_start    out  frame marker beat
//   tx_bit      out  serial data
//   tx_valid    out  tx_bit holds a data/parity beat
//   busy        out  frame in progress (load ignored)
//   done        out  one-cycle pulse after the last beat
//   o_dbg_state out  current FSM state encoding
module cpu_serial_tx #(
    parameter int DATA_W = 8,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] y_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_SHIFT_Y = 3'd2,
        S_SHIFT_F = 3'd3,
`ifdef CPU_SERIAL_TX_PARITY_EN
        S_PARITY  = 3'd4,
`endif
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_y;
    logic [FLAG_W-1:0] r_flags;

    logic [2:0]        w_cnt_nxt;

    // The next beat's bit is registered together with the counter advance,
    // so index the shadow with the incremented count.
    assign w_cnt_nxt   = r_cnt + 3'd1;
    assign o_dbg_state = r_state;

`ifdef CPU_SERIAL_TX_PARITY_EN
    logic w_parity;
    assign w_parity = (^r_y) ^ (^r_flags);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_y      <= '0;
            r_flags  <= '0;
            tx_start <= 1'b0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_y      <= y_in;
                        r_flags  <= flags_in;
                        r_cnt    <= 3'd0;
                        r_state  <= S_START;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                S_START: begin
                    if (tx_ready) begin
                        r_state  <= S_SHIFT_Y;
                        tx_start <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_bit   <= r_y[7];
                    end
                end

                S_SHIFT_Y: begin
                    if (tx_ready) begin
                        if (r_cnt == 3'd7) begin
                            r_cnt   <= 3'd0;
                            r_state <= S_SHIFT_F;
                            tx_bit  <= r_flags[3];
                        end else begin
                            r_cnt  <= w_cnt_nxt;
                            tx_bit <= r_y[3'd7 - w_cnt_nxt];
                        end
                    end
                end

                S_SHIFT_F: begin
                    if (tx_ready) begin
                        if (r_cnt == 3'd3) begin
                            r_cnt <= 3'd0;
`ifdef CPU_SERIAL_TX_PARITY_EN
                            r_state <= S_PARITY;
                            tx_bit  <= w_parity;
`else
                            r_state  <= S_DONE;
                            tx_valid <= 1'b0;
                            tx_bit   <= 1'b0;
                            done     <= 1'b1;
`endif
                        end else begin
                            r_cnt  <= w_cnt_nxt;
                            tx_bit <= r_flags[2'd3 - w_cnt_nxt[1:0]];
                        end
                    end
                end

`ifdef CPU_SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (tx_ready) begin
                        r_state  <= S_DONE;
                        tx_valid <= 1'b0;
                        tx_bit   <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif

                // One cycle only, independent of tx_ready; a load seen here
                // is dropped because the FSM is not yet back in IDLE.
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= 3'd0;
                    tx_start <= 1'b0;
                    tx_bit   <= 1'b0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
